// File: rtl/moldudp_pkg.sv
// Shared definitions for the MoldUDP64 frame sequencer.
// Holds the sequencer state encoding, the default frame-header offsets,
// the MoldUDP64 header field sizes, the heartbeat count value and a small
// helper used when advancing the expected sequence number.
package moldudp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NET_HDR,
        ST_MOLD_HDR,
        ST_MLEN_HI,
        ST_MLEN_LO,
        ST_MSG_BODY,
        ST_DRAIN
    } state_e;

    // Ethernet + VLAN + IPv4 + UDP header geometry
    localparam int HDR_BYTES_DEF   = 46;
    localparam int UDP_LEN_OFF_DEF = 42;
    localparam int UDP_HDR_LEN     = 8;
    localparam int MAX_MSG_LEN_DEF = 64;

    // MoldUDP64 header: session, sequence number, message count
    localparam int MOLD_SESSION_LEN = 10;
    localparam int MOLD_SEQ_LEN     = 8;
    localparam int MOLD_COUNT_LEN   = 2;
    localparam int MOLD_HDR_LEN     = MOLD_SESSION_LEN + MOLD_SEQ_LEN + MOLD_COUNT_LEN;

    localparam logic [15:0] HB_COUNT = 16'hFFFF;

    function automatic logic [63:0] seq_max(input logic [63:0] a, input logic [63:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/moldudp_seq_tracker.sv
// Sequence-number bookkeeping for the MoldUDP64 sequencer.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   check_i          header complete: run the gap check on seq_i
//   update_i         packet done: expected = max(expected, upd_seq_i)
//   seq_i            sequence number of the packet / current message
//   upd_seq_i        candidate next-expected value
//   dup_o            seq_i lies behind the expected sequence (combinational)
//   gap_pulse_o      registered gap strobe
//   gap_count_o      registered missing-message count, saturated to 16 bits
//   expected_seq_o   next expected sequence number
module moldudp_seq_tracker
    import moldudp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        check_i,
    input  logic        update_i,
    input  logic [63:0] seq_i,
    input  logic [63:0] upd_seq_i,
    output logic        dup_o,
    output logic        gap_pulse_o,
    output logic [15:0] gap_count_o,
    output logic [63:0] expected_seq_o
);

    logic [63:0] expected_q, expected_d;
    logic        known_q, known_d;
    logic        gap_q, gap_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [63:0] diff;

    always_comb begin
        diff       = seq_i - expected_q;
        expected_d = update_i ? seq_max(expected_q, upd_seq_i) : expected_q;
        known_d    = known_q | check_i;
        // The very first header only arms the tracker; it cannot be a gap.
        gap_d      = check_i && known_q && (seq_i > expected_q);
        gap_cnt_d  = gap_cnt_q;
        if (gap_d) begin
            gap_cnt_d = (|diff[63:16]) ? 16'hFFFF : diff[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            expected_q <= '0;
            known_q    <= 1'b0;
            gap_q      <= 1'b0;
            gap_cnt_q  <= '0;
        end else begin
            expected_q <= expected_d;
            known_q    <= known_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign dup_o          = known_q && (seq_i < expected_q);
    assign gap_pulse_o    = gap_q;
    assign gap_count_o    = gap_cnt_q;
    assign expected_seq_o = expected_q;

endmodule

// File: rtl/moldudp_frame_sequencer.sv
// Front-end controller of the ITCH decode path. Walks each captured frame
// (network header, MoldUDP64 header, length-prefixed messages) and forwards
// only message bytes, one cycle after they arrive, framed by msg_sof/msg_eof
// and tagged with the message sequence number. Flags heartbeats, sequence
// gaps and malformed packets; duplicates are walked but not emitted.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   in_valid/in_sof/in_eof/in_data      captured frame byte stream
//   msg_valid/msg_sof/msg_eof/msg_data  message byte stream to the decoder
//   msg_seq                             sequence number of the current message
//   msg_abort                           message in flight was truncated
//   hb_pulse, gap_pulse, gap_count      heartbeat / gap indications
//   err_pulse                           malformed or truncated packet
//   expected_seq                        next expected sequence number
module moldudp_frame_sequencer
    import moldudp_pkg::*;
#(
    parameter int HDR_BYTES   = HDR_BYTES_DEF,
    parameter int UDP_LEN_OFF = UDP_LEN_OFF_DEF,
    parameter int MAX_MSG_LEN = MAX_MSG_LEN_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eof,
    input  logic [7:0]  in_data,
    output logic        msg_valid,
    output logic        msg_sof,
    output logic        msg_eof,
    output logic [7:0]  msg_data,
    output logic [63:0] msg_seq,
    output logic        msg_abort,
    output logic        hb_pulse,
    output logic        gap_pulse,
    output logic [15:0] gap_count,
    output logic        err_pulse,
    output logic [63:0] expected_seq
);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;          // index of the byte now arriving
    logic [15:0] udp_len_q, udp_len_d;
    logic [15:0] count_q, count_d;
    logic [15:0] done_q, done_d;        // messages completed in this packet
    logic [15:0] rem_q, rem_d;          // body bytes still to come
    logic [7:0]  mlen_hi_q, mlen_hi_d;
    logic [63:0] seq_q, seq_d;
    logic        emit_q, emit_d, first_q, first_d;
    logic        mvld_q, mvld_d, msof_q, msof_d, meof_q, meof_d;
    logic [7:0]  mdata_q, mdata_d;
    logic [63:0] mseq_q, mseq_d;
    logic        abort_q, abort_d, hb_q, hb_d, err_q, err_d;

    logic [15:0] mold_off, mlen_w, count_w;
    logic [17:0] body_end, pay_end;
    logic        cut, trk_check, trk_update, dup;
    logic [63:0] upd_seq;

    moldudp_seq_tracker u_trk (
        .clk            (clk),
        .reset          (reset),
        .check_i        (trk_check),
        .update_i       (trk_update),
        .seq_i          (seq_q),
        .upd_seq_i      (upd_seq),
        .dup_o          (dup),
        .gap_pulse_o    (gap_pulse),
        .gap_count_o    (gap_count),
        .expected_seq_o (expected_seq)
    );

    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;  udp_len_d = udp_len_q;
        count_d = count_q;  done_d = done_q;  rem_d = rem_q;
        mlen_hi_d = mlen_hi_q;  seq_d = seq_q;  emit_d = emit_q;  first_d = first_q;
        mvld_d = 1'b0;  msof_d = 1'b0;  meof_d = 1'b0;
        mdata_d = mdata_q;  mseq_d = mseq_q;
        abort_d = 1'b0;  hb_d = 1'b0;  err_d = 1'b0;
        cut = 1'b0;  trk_check = 1'b0;  trk_update = 1'b0;  upd_seq = seq_q;

        mold_off = cnt_q - 16'(HDR_BYTES);
        mlen_w   = {mlen_hi_q, in_data};
        count_w  = {count_q[15:8], in_data};
        // A message must end inside the UDP payload (UDP length minus its header).
        body_end = {2'b0, cnt_q} + {2'b0, mlen_w} + 18'd1;
        pay_end  = 18'(HDR_BYTES) + {2'b0, udp_len_q} - 18'(UDP_HDR_LEN);

        if (in_valid) begin
            cnt_d = cnt_q + 16'd1;
            if (in_sof) begin
                // A new frame abandons whatever was in progress.
                cut     = (state_q != ST_IDLE) && (state_q != ST_DRAIN);
                cnt_d   = 16'd1;
                done_d  = '0;
                count_d = '0;
                seq_d   = '0;
                state_d = in_eof ? ST_IDLE : ST_NET_HDR;
                err_d   = in_eof;
            end else begin
                case (state_q)
                    ST_NET_HDR: begin
                        if (cnt_q == 16'(UDP_LEN_OFF))     udp_len_d = {in_data, udp_len_q[7:0]};
                        if (cnt_q == 16'(UDP_LEN_OFF + 1)) udp_len_d = {udp_len_q[15:8], in_data};
                        if (in_eof) begin
                            cut = 1'b1;
                            state_d = ST_IDLE;
                        end else if (cnt_q == 16'(HDR_BYTES - 1)) begin
                            state_d = ST_MOLD_HDR;
                        end
                    end
                    ST_MOLD_HDR: begin
                        if (mold_off >= 16'(MOLD_SESSION_LEN) &&
                            mold_off <  16'(MOLD_SESSION_LEN + MOLD_SEQ_LEN)) begin
                            seq_d = {seq_q[55:0], in_data};
                        end
                        if (mold_off == 16'(MOLD_HDR_LEN - 2)) count_d = {in_data, 8'h00};
                        if (mold_off == 16'(MOLD_HDR_LEN - 1)) begin
                            count_d = count_w;
                            if (count_w == HB_COUNT || count_w == 16'd0) begin
                                hb_d       = 1'b1;
                                trk_check  = 1'b1;
                                trk_update = 1'b1;
                                state_d    = in_eof ? ST_IDLE : ST_DRAIN;
                            end else if (in_eof) begin
                                cut = 1'b1;
                                state_d = ST_IDLE;
                            end else begin
                                trk_check = 1'b1;
                                state_d   = ST_MLEN_HI;
                            end
                        end else if (in_eof) begin
                            cut = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_MLEN_HI: begin
                        mlen_hi_d = in_data;
                        if (in_eof) begin
                            cut = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_MLEN_LO;
                        end
                    end
                    ST_MLEN_LO: begin
                        if (in_eof) begin
                            cut = 1'b1;
                            state_d = ST_IDLE;
                        end else if (mlen_w == 16'd0 || mlen_w > 16'(MAX_MSG_LEN) ||
                                     body_end > pay_end) begin
                            err_d   = 1'b1;
                            state_d = ST_DRAIN;
                        end else begin
                            rem_d   = mlen_w;
                            emit_d  = !dup;
                            first_d = 1'b1;
                            state_d = ST_MSG_BODY;
                        end
                    end
                    ST_MSG_BODY: begin
                        if (in_eof && rem_q != 16'd1) begin
                            // The truncating byte itself is not forwarded.
                            cut = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            mvld_d  = emit_q;
                            msof_d  = emit_q && first_q;
                            if (emit_q) begin
                                mdata_d = in_data;
                                mseq_d  = seq_q;
                            end
                            first_d = 1'b0;
                            rem_d   = rem_q - 16'd1;
                            if (rem_q == 16'd1) begin
                                meof_d  = emit_q;
                                seq_d   = seq_q + 64'd1;
                                done_d  = done_q + 16'd1;
                                upd_seq = seq_q + 64'd1;
                                if (done_q + 16'd1 == count_q) begin
                                    trk_update = 1'b1;
                                    state_d    = in_eof ? ST_IDLE : ST_DRAIN;
                                end else if (in_eof) begin
                                    err_d      = 1'b1;
                                    trk_update = 1'b1;
                                    state_d    = ST_IDLE;
                                end else begin
                                    state_d = ST_MLEN_HI;
                                end
                            end
                        end
                    end
                    ST_DRAIN: if (in_eof) state_d = ST_IDLE;
                    default: ;
                endcase
            end
            if (cut) begin
                err_d   = 1'b1;
                abort_d = (state_q == ST_MSG_BODY) && emit_q;
                if (done_q != 16'd0) trk_update = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;  cnt_q <= '0;  udp_len_q <= '0;
            count_q <= '0;  done_q <= '0;  rem_q <= '0;  mlen_hi_q <= '0;
            seq_q <= '0;  emit_q <= 1'b0;  first_q <= 1'b0;
            mvld_q <= 1'b0;  msof_q <= 1'b0;  meof_q <= 1'b0;
            mdata_q <= '0;  mseq_q <= '0;
            abort_q <= 1'b0;  hb_q <= 1'b0;  err_q <= 1'b0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  udp_len_q <= udp_len_d;
            count_q <= count_d;  done_q <= done_d;  rem_q <= rem_d;  mlen_hi_q <= mlen_hi_d;
            seq_q <= seq_d;  emit_q <= emit_d;  first_q <= first_d;
            mvld_q <= mvld_d;  msof_q <= msof_d;  meof_q <= meof_d;
            mdata_q <= mdata_d;  mseq_q <= mseq_d;
            abort_q <= abort_d;  hb_q <= hb_d;  err_q <= err_d;
        end
    end

    assign msg_valid = mvld_q;
    assign msg_sof   = msof_q;
    assign msg_eof   = meof_q;
    assign msg_data  = mdata_q;
    assign msg_seq   = mseq_q;
    assign msg_abort = abort_q;
    assign hb_pulse  = hb_q;
    assign err_pulse = err_q;

endmodule

// File: tb/tb_moldudp_frame_sequencer.sv
// Directed bench for moldudp_frame_sequencer: builds whole frames
// (network header with a consistent UDP length, MoldUDP64 header, messages)
// and compares event counts collected by a negedge monitor against
// hand-computed values.
module tb_moldudp_frame_sequencer;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_sof, in_eof;
    logic [7:0]  in_data;
    logic        msg_valid, msg_sof, msg_eof, msg_abort, hb_pulse, gap_pulse, err_pulse;
    logic [7:0]  msg_data;
    logic [63:0] msg_seq, expected_seq;
    logic [15:0] gap_count;

    always #5 clk = ~clk;

    moldudp_frame_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .in_eof       (in_eof),
        .in_data      (in_data),
        .msg_valid    (msg_valid),
        .msg_sof      (msg_sof),
        .msg_eof      (msg_eof),
        .msg_data     (msg_data),
        .msg_seq      (msg_seq),
        .msg_abort    (msg_abort),
        .hb_pulse     (hb_pulse),
        .gap_pulse    (gap_pulse),
        .gap_count    (gap_count),
        .err_pulse    (err_pulse),
        .expected_seq (expected_seq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- monitor (cumulative counts) ----------------
    int m_valid = 0, m_sof = 0, m_eof = 0, m_abort = 0, m_err = 0;
    int m_hb = 0, m_gap = 0, m_abort_err = 0;
    logic [15:0] m_gap_count = '0;
    logic [63:0] sof_seq[$];
    logic [7:0]  sof_type[$];

    always @(negedge clk) begin
        if (msg_valid) m_valid++;
        if (msg_valid && msg_sof) begin
            m_sof++;
            sof_seq.push_back(msg_seq);
            sof_type.push_back(msg_data);
        end
        if (msg_valid && msg_eof) m_eof++;
        if (msg_abort) m_abort++;
        if (err_pulse) m_err++;
        if (msg_abort && err_pulse) m_abort_err++;
        if (hb_pulse) m_hb++;
        if (gap_pulse) begin
            m_gap++;
            m_gap_count = gap_count;
        end
    end

    int b_valid, b_sof, b_eof, b_abort, b_err, b_hb, b_gap, b_abort_err, b_q;

    task automatic snap();
        b_valid = m_valid;  b_sof = m_sof;  b_eof = m_eof;  b_abort = m_abort;
        b_err = m_err;  b_hb = m_hb;  b_gap = m_gap;  b_abort_err = m_abort_err;
        b_q = sof_seq.size();
    endtask

    function automatic logic [63:0] q_seq(input int idx);
        return (idx < sof_seq.size()) ? sof_seq[idx] : 64'hDEAD;
    endfunction

    function automatic logic [7:0] q_type(input int idx);
        return (idx < sof_type.size()) ? sof_type[idx] : 8'h00;
    endfunction

    // ---------------- frame construction ----------------
    logic [7:0] pl[$];
    logic [7:0] fr[$];

    task automatic pl_mold(input logic [63:0] seq, input logic [15:0] cnt);
        for (int i = 0; i < 10; i++) pl.push_back(8'h41 + 8'(i));
        for (int i = 7; i >= 0; i--) pl.push_back(seq[i*8 +: 8]);
        pl.push_back(cnt[15:8]);
        pl.push_back(cnt[7:0]);
    endtask

    task automatic pl_msg(input int len, input logic [7:0] typ, input int nbody);
        logic [15:0] l16;
        l16 = 16'(len);
        pl.push_back(l16[15:8]);
        pl.push_back(l16[7:0]);
        pl.push_back(typ);
        for (int i = 1; i < nbody; i++) pl.push_back(8'(i));
    endtask

    task automatic build_frame();
        logic [15:0] udp;
        udp = 16'(8 + pl.size());
        fr.delete();
        for (int i = 0; i < 46; i++) begin
            if (i == 42)      fr.push_back(udp[15:8]);
            else if (i == 43) fr.push_back(udp[7:0]);
            else              fr.push_back(8'(i) ^ 8'h5a);
        end
        foreach (pl[i]) fr.push_back(pl[i]);
        pl.delete();
    endtask

    // Sends the first n bytes of fr, eof on the last one; idle gaps exercise freezing.
    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 7 == 3) begin
                @(negedge clk);
                in_valid = 1'b0;  in_sof = 1'b0;  in_eof = 1'b0;
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_sof   = (i == 0);
            in_eof   = (i == n - 1);
            in_data  = fr[i];
        end
        @(negedge clk);
        in_valid = 1'b0;  in_sof = 1'b0;  in_eof = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input int ncut);
        build_frame();
        send_bytes(fr.size() - ncut);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;  in_valid = 1'b0;  in_sof = 1'b0;  in_eof = 1'b0;  in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_msg_valid", msg_valid, 0);
        chk("rst_expected",  expected_seq, 0);
        chk("rst_msg_seq",   msg_seq, 0);
        chk("rst_pulses",    {msg_sof, msg_eof, msg_abort, hb_pulse, gap_pulse, err_pulse}, 0);
        reset = 1'b0;
        @(negedge clk);

        // two messages, seq 100
        snap();
        pl_mold(64'd100, 16'd2);
        pl_msg(12, 8'h53, 12);
        pl_msg(36, 8'h41, 36);
        send_frame(0);
        chk("t1_valid_bytes", m_valid - b_valid, 48);
        chk("t1_sof_cnt",     m_sof - b_sof, 2);
        chk("t1_eof_cnt",     m_eof - b_eof, 2);
        chk("t1_type0",       q_type(b_q), 8'h53);
        chk("t1_seq0",        q_seq(b_q), 100);
        chk("t1_type1",       q_type(b_q + 1), 8'h41);
        chk("t1_seq1",        q_seq(b_q + 1), 101);
        chk("t1_expected",    expected_seq, 102);
        chk("t1_no_gap_err",  (m_gap - b_gap) + (m_err - b_err), 0);

        // gap of three
        snap();
        pl_mold(64'd105, 16'd1);
        pl_msg(36, 8'h41, 36);
        send_frame(0);
        chk("t2_gap_cnt",    m_gap - b_gap, 1);
        chk("t2_gap_count",  m_gap_count, 3);
        chk("t2_valid",      m_valid - b_valid, 36);
        chk("t2_seq",        q_seq(b_q), 105);
        chk("t2_expected",   expected_seq, 106);

        // replay 104..106: only 106 emitted
        snap();
        pl_mold(64'd104, 16'd3);
        pl_msg(12, 8'h53, 12);
        pl_msg(36, 8'h41, 36);
        pl_msg(31, 8'h45, 31);
        send_frame(0);
        chk("t3_sof_cnt",   m_sof - b_sof, 1);
        chk("t3_valid",     m_valid - b_valid, 31);
        chk("t3_seq",       q_seq(b_q), 106);
        chk("t3_type",      q_type(b_q), 8'h45);
        chk("t3_no_gap",    m_gap - b_gap, 0);
        chk("t3_expected",  expected_seq, 107);

        // heartbeat
        snap();
        pl_mold(64'd107, 16'hFFFF);
        send_frame(0);
        chk("t4_hb",        m_hb - b_hb, 1);
        chk("t4_valid",     m_valid - b_valid, 0);
        chk("t4_no_gap",    m_gap - b_gap, 0);
        chk("t4_expected",  expected_seq, 107);

        // oversize message length, then a normal frame
        snap();
        pl_mold(64'd107, 16'd1);
        pl_msg(200, 8'h58, 10);
        send_frame(0);
        chk("t5_err",       m_err - b_err, 1);
        chk("t5_valid",     m_valid - b_valid, 0);
        chk("t5_expected",  expected_seq, 107);
        snap();
        pl_mold(64'd107, 16'd1);
        pl_msg(12, 8'h53, 12);
        send_frame(0);
        chk("t5b_valid",    m_valid - b_valid, 12);
        chk("t5b_seq",      q_seq(b_q), 107);
        chk("t5b_err",      m_err - b_err, 0);
        chk("t5b_expected", expected_seq, 108);

        // eof five bytes into a 36-byte body
        snap();
        pl_mold(64'd108, 16'd1);
        pl_msg(36, 8'h41, 36);
        send_frame(31);
        chk("t6_abort_err", m_abort_err - b_abort_err, 1);
        chk("t6_abort",     m_abort - b_abort, 1);
        chk("t6_err",       m_err - b_err, 1);
        chk("t6_no_eof",    m_eof - b_eof, 0);
        chk("t6_expected",  expected_seq, 108);
        snap();
        pl_mold(64'd108, 16'd1);
        pl_msg(12, 8'h53, 12);
        send_frame(0);
        chk("t6b_valid",    m_valid - b_valid, 12);
        chk("t6b_expected", expected_seq, 109);

        // heartbeat far ahead: saturated gap count
        snap();
        pl_mold(64'h20000, 16'd0);
        send_frame(0);
        chk("t7_hb",        m_hb - b_hb, 1);
        chk("t7_gap_count", m_gap_count, 16'hFFFF);
        chk("t7_expected",  expected_seq, 64'h20000);

        // reset in the middle of a message body
        snap();
        pl_mold(64'h20000, 16'd1);
        pl_msg(36, 8'h41, 36);
        build_frame();
        for (int i = 0; i < 72; i++) begin
            @(negedge clk);
            in_valid = 1'b1;  in_sof = (i == 0);  in_eof = 1'b0;  in_data = fr[i];
        end
        @(negedge clk);
        chk("t8_pre_valid", msg_valid, 1);
        in_valid = 1'b0;  in_sof = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("t8_valid",     msg_valid, 0);
        chk("t8_expected",  expected_seq, 0);
        chk("t8_msg_seq",   msg_seq, 0);
        chk("t8_gap_count", gap_count, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("t8_no_abort",  m_abort - b_abort, 0);

        // one-byte frame
        snap();
        fr.delete();
        fr.push_back(8'h11);
        send_bytes(1);
        chk("t9_err",       m_err - b_err, 1);
        chk("t9_valid",     m_valid - b_valid, 0);

        // first packet after reset: no gap, normal decode
        snap();
        pl_mold(64'd500, 16'd1);
        pl_msg(12, 8'h53, 12);
        send_frame(0);
        chk("t10_no_gap",   m_gap - b_gap, 0);
        chk("t10_valid",    m_valid - b_valid, 12);
        chk("t10_seq",      q_seq(b_q), 500);
        chk("t10_expected", expected_seq, 501);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
